// File: rtl/csr_bus_pkg.sv
// Shared types and index helpers for the CSR bus arbiter.
package csr_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam int OWNER_W = 3;

    // Bits needed to index n items; never below 1 so ports stay legal.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Low bit of slice idx in a concatenated vector of w-bit fields.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/csr_bus_arbiter_rr_arbiter.sv
// Round-robin winner selection; pointer moves to owner+1 on each completion.
module rr_arbiter
    import csr_bus_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic               done,
    input  logic [OWNER_W-1:0] done_idx,
    output logic [N-1:0]       grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr;
    int               base;
    int               idx;
    logic             found;

    // On the completion cycle the search already starts from the advanced
    // pointer, so a re-grant can be issued without an extra idle cycle.
    always_comb begin
        base      = done ? (int'(done_idx) + 1) % N : int'(ptr);
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (base + k) % N;
            if (!found && req[IDX_W'(idx)]) begin
                found                = 1'b1;
                grant[IDX_W'(idx)]   = 1'b1;
                grant_idx            = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (done)
            ptr <= IDX_W'((int'(done_idx) + 1) % N);
    end

endmodule

// File: rtl/csr_bus_arbiter.sv
// Round-robin arbiter sharing one strobe-decoded CSR bus among several masters.
module csr_bus_arbiter
    import csr_bus_pkg::*;
#(
    parameter int NUM_REQUESTERS       = 2,
    parameter int CSR_DATA_BUS_WIDTH   = 32,
    parameter int CSR_STROBE_BUS_WIDTH = 8,
    parameter int SEL_WIDTH            = 3,
    parameter int READ_WAIT            = 2
)(
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_REQUESTERS-1:0]                      req_valid,
    input  logic [NUM_REQUESTERS-1:0]                      req_rw,
    input  logic [NUM_REQUESTERS*SEL_WIDTH-1:0]            req_sel,
    input  logic [NUM_REQUESTERS*CSR_DATA_BUS_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQUESTERS-1:0]                      req_ready,
    output logic [NUM_REQUESTERS-1:0]                      rsp_valid,
    output logic [CSR_DATA_BUS_WIDTH-1:0]                  rsp_rdata,
    output logic                                           rsp_err,
    output logic [CSR_STROBE_BUS_WIDTH-1:0]                csr_stb_o,
    output logic [CSR_DATA_BUS_WIDTH-1:0]                  csr_data_o,
    input  logic [CSR_STROBE_BUS_WIDTH*CSR_DATA_BUS_WIDTH-1:0] csr_data_i,
    output logic                                           csr_rw,
    output logic                                           csr_in_progress,
    output logic [OWNER_W-1:0]                             csr_owner
);

    localparam int NR    = NUM_REQUESTERS;
    localparam int DW    = CSR_DATA_BUS_WIDTH;
    localparam int STB   = CSR_STROBE_BUS_WIDTH;
    localparam int SW    = SEL_WIDTH;
    localparam int IDX_W = sel_width(NR);
    localparam int CNT_W = sel_width(READ_WAIT + 1);

    state_t           state, state_n;
    logic [NR-1:0]    grant;
    logic [IDX_W-1:0] grant_idx;
    logic [SW-1:0]    sel_q;
    logic [DW-1:0]    wdata_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             pending, done, grant_fire, access_last, sel_oob;
    int               rd_idx;
    logic [DW-1:0]    rd_word;

    assign pending = |req_ready;
    assign done    = (state == RESPOND);
    assign sel_oob = int'(sel_q) >= STB;
    assign rd_idx  = sel_oob ? 0 : int'(sel_q);
    assign rd_word = csr_data_i[slice_lo(rd_idx, DW) +: DW];

    rr_arbiter #(.N(NR), .IDX_W(IDX_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .done      (done),
        .done_idx  (csr_owner),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Grant decisions are made one edge ahead so req_ready leaves a flop;
    // RESPOND may re-grant directly, giving one write per three cycles.
    always_comb begin
        state_n     = state;
        grant_fire  = 1'b0;
        access_last = 1'b0;
        case (state)
            IDLE: begin
                grant_fire = !pending && (|req_valid);
                if (pending)
                    state_n = ACCESS;
            end
            ACCESS: begin
                access_last = csr_rw || (int'(wait_cnt) == READ_WAIT - 1);
                if (access_last)
                    state_n = RESPOND;
            end
            RESPOND: begin
                grant_fire = |req_valid;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready       <= '0;
            rsp_valid       <= '0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
            csr_stb_o       <= '0;
            csr_data_o      <= '0;
            csr_rw          <= 1'b0;
            csr_in_progress <= 1'b0;
            csr_owner       <= '0;
            sel_q           <= '0;
            wdata_q         <= '0;
            wait_cnt        <= '0;
        end else begin
            req_ready       <= '0;
            rsp_valid       <= '0;
            csr_stb_o       <= '0;
            csr_in_progress <= (state_n == ACCESS);

            if (grant_fire) begin
                req_ready <= grant;
                csr_owner <= OWNER_W'(grant_idx);
                csr_rw    <= req_rw[grant_idx];
                sel_q     <= req_sel[slice_lo(int'(grant_idx), SW) +: SW];
                wdata_q   <= req_wdata[slice_lo(int'(grant_idx), DW) +: DW];
            end

            if (state == IDLE && pending) begin
                wait_cnt   <= '0;
                csr_data_o <= wdata_q;
                if (csr_rw && !sel_oob)
                    csr_stb_o <= STB'(1) << sel_q;
            end

            if (state == ACCESS) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (access_last) begin
                    rsp_valid <= NR'(1) << csr_owner;
                    rsp_err   <= sel_oob;
                    rsp_rdata <= (csr_rw || sel_oob) ? '0 : rd_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Randomised and directed checks of the CSR bus arbiter against a spec-level model.
module tb_csr_bus_arbiter;

    localparam int NR  = 2;
    localparam int DW  = 32;
    localparam int STB = 6;
    localparam int SW  = 3;
    localparam int RW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_rw;
    logic [NR*SW-1:0]  req_sel;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready, rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [STB-1:0]    csr_stb_o;
    logic [DW-1:0]     csr_data_o;
    logic [STB*DW-1:0] csr_data_i;
    logic              csr_rw, csr_in_progress;
    logic [2:0]        csr_owner;
    logic [DW-1:0]     regs [STB];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        csr_data_i = '0;
        for (int i = 0; i < STB; i++) csr_data_i[i*DW +: DW] = regs[i];
    end

    csr_bus_arbiter #(
        .NUM_REQUESTERS(NR), .CSR_DATA_BUS_WIDTH(DW), .CSR_STROBE_BUS_WIDTH(STB),
        .SEL_WIDTH(SW), .READ_WAIT(RW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rw(req_rw), .req_sel(req_sel), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .csr_stb_o(csr_stb_o), .csr_data_o(csr_data_o), .csr_data_i(csr_data_i),
        .csr_rw(csr_rw), .csr_in_progress(csr_in_progress), .csr_owner(csr_owner)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One transaction from requester r; expectations come straight from the bus rules.
    task automatic run_txn(input string tag, input int r, input bit rw, input int sel, input int wd);
        int          t;
        int          lat;
        bit          exp_err;
        logic [STB-1:0] exp_stb;
        logic [DW-1:0]  exp_rd;
        exp_err = (sel >= STB);
        exp_stb = (rw && !exp_err) ? (STB'(1) << sel) : '0;
        exp_rd  = (rw || exp_err) ? '0 : regs[sel];
        lat     = rw ? 1 : RW;

        req_valid[r] = 1'b1;
        req_rw[r]    = rw;
        req_sel[r*SW +: SW]   = SW'(sel);
        req_wdata[r*DW +: DW] = DW'(wd);
        t = 0;
        do begin
            tick();
            t++;
        end while (req_ready == '0 && t < 20);

        n_checks++;
        if (req_ready !== (NR'(1) << r)) begin
            n_fail++;
            $display("FAIL %s ready: got %b want %b", tag, req_ready, NR'(1) << r);
            req_valid[r] = 1'b0;
            return;
        end
        n_checks++;
        if (csr_owner !== 3'(r) || csr_rw !== rw || csr_in_progress !== 1'b0) begin
            n_fail++;
            $display("FAIL %s grant: owner %0d rw %b busy %b want %0d %b 0",
                     tag, csr_owner, csr_rw, csr_in_progress, r, rw);
        end

        // After accept the inputs are don't-care; scramble them.
        req_valid[r] = 1'b0;
        req_rw[r]    = 1'($urandom);
        req_sel[r*SW +: SW]   = SW'($urandom);
        req_wdata[r*DW +: DW] = $urandom;

        for (int c = 1; c <= lat; c++) begin
            tick();
            n_checks++;
            if (csr_in_progress !== 1'b1 || rsp_valid !== '0 ||
                csr_stb_o !== ((c == 1) ? exp_stb : STB'(0))) begin
                n_fail++;
                $display("FAIL %s access%0d: busy %b rsp %b stb %h want 1 00 %h",
                         tag, c, csr_in_progress, rsp_valid, csr_stb_o, (c == 1) ? exp_stb : STB'(0));
            end
            if (rw) begin
                n_checks++;
                if (csr_data_o !== DW'(wd)) begin
                    n_fail++;
                    $display("FAIL %s wdata: got %h want %h", tag, csr_data_o, DW'(wd));
                end
            end
        end

        tick();
        n_checks++;
        if (rsp_valid !== (NR'(1) << r) || rsp_err !== exp_err || rsp_rdata !== exp_rd ||
            csr_in_progress !== 1'b0 || csr_stb_o !== '0) begin
            n_fail++;
            $display("FAIL %s rsp: vld %b err %b rdata %h busy %b stb %h want %b %b %h 0 00",
                     tag, rsp_valid, rsp_err, rsp_rdata, csr_in_progress, csr_stb_o,
                     NR'(1) << r, exp_err, exp_rd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        req_rw = '1;
        tick();
        tick();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, csr_stb_o, csr_data_o,
             csr_rw, csr_in_progress, csr_owner} !== '0) begin
            n_fail++;
            $display("FAIL reset: ready %b rsp %b rdata %h err %b stb %h data %h rw %b busy %b own %0d want all 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, csr_stb_o, csr_data_o,
                     csr_rw, csr_in_progress, csr_owner);
        end
        req_valid = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        run_txn("single_write", 0, 1'b1, 5, 32'h2A);
    endtask

    task automatic test_single_read();
        regs[3] = 32'h1F4;
        run_txn("single_read", 1, 1'b0, 3, 0);
    endtask

    task automatic test_out_of_range();
        run_txn("oor_write", 0, 1'b1, 7, 32'h55);
        run_txn("oor_read", 1, 1'b0, 6, 0);
    endtask

    // Both masters hold requests; grants follow the round-robin rule, 3 cycles apart.
    task automatic test_back_to_back();
        int exp_order[4];
        int ptr, ng, nr, cyc, last_cyc, last_grant, idx;
        apply_reset();
        ptr = 0;
        for (int k = 0; k < 4; k++) begin
            exp_order[k] = ptr;
            ptr = (ptr + 1) % NR;
        end
        req_rw = '1;
        req_sel = {3'd2, 3'd1};
        req_wdata = {32'h22, 32'h11};
        req_valid = '1;
        ng = 0; nr = 0; cyc = 0; last_cyc = 0; last_grant = 0;
        while (nr < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (req_ready != '0 && ng < 4) begin
                idx = 0;
                for (int i = 0; i < NR; i++) if (req_ready[i]) idx = i;
                n_checks++;
                if ($countones(req_ready) != 1 || idx != exp_order[ng] ||
                    (ng > 0 && cyc - last_cyc != 3)) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d: ready %b gap %0d want one-hot idx %0d gap 3",
                             ng, req_ready, cyc - last_cyc, exp_order[ng]);
                end
                last_grant = idx;
                last_cyc = cyc;
                ng++;
            end
            if (rsp_valid != '0) begin
                n_checks++;
                if (rsp_valid !== (NR'(1) << last_grant)) begin
                    n_fail++;
                    $display("FAIL rr_rsp%0d: got %b want %b", nr, rsp_valid, NR'(1) << last_grant);
                end
                nr++;
            end
        end
        n_checks++;
        if (nr < 4) begin
            n_fail++;
            $display("FAIL rr_timeout: responses %0d want 4", nr);
        end
        req_valid = '0;
        apply_reset();
    endtask

    task automatic test_reset_mid_read();
        int t;
        apply_reset();
        run_txn("pre_abort", 0, 1'b1, 0, 32'h77);
        req_valid[1] = 1'b1;
        req_rw[1] = 1'b0;
        req_sel[SW +: SW] = 3'd2;
        t = 0;
        do begin
            tick();
            t++;
        end while (req_ready == '0 && t < 20);
        req_valid[1] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, csr_stb_o, csr_data_o,
             csr_rw, csr_in_progress, csr_owner} !== '0) begin
            n_fail++;
            $display("FAIL abort_reset: busy %b rsp %b stb %h own %0d rw %b want all 0",
                     csr_in_progress, rsp_valid, csr_stb_o, csr_owner, csr_rw);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (rsp_valid !== '0) begin
                n_fail++;
                $display("FAIL abort_no_rsp: got %b want 00", rsp_valid);
            end
        end
        req_rw = '0;
        req_valid = '1;
        t = 0;
        do begin
            tick();
            t++;
        end while (req_ready == '0 && t < 20);
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_regrant: got %b want 01", req_ready);
        end
        req_valid = '0;
        apply_reset();
    endtask

    task automatic test_random_sweep();
        for (int i = 0; i < STB; i++) regs[i] = DW'($urandom_range(0, 999));
        for (int k = 0; k < 10; k++)
            run_txn("rand_write", int'($urandom_range(0, NR-1)), 1'b1,
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 999)));
        for (int k = 0; k < 10; k++)
            run_txn("rand_read", int'($urandom_range(0, NR-1)), 1'b0,
                    int'($urandom_range(0, 7)), 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_rw = '0;
        req_sel = '0;
        req_wdata = '0;
        for (int i = 0; i < STB; i++) regs[i] = DW'(i * 16 + 1);
        test_reset();
        test_single_write();
        test_single_read();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_read();
        test_random_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
